// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: turns SPI slave byte stream into register bank accesses
module spi_reg_bridge #(
    parameter int         NUM_REGS    = 16,
    parameter logic [7:0] STATUS_BYTE = 8'hA5,
    parameter logic [7:0] ERR_BYTE    = 8'hEE,
    parameter logic [7:0] RST_VAL     = 8'h00
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  cs,
    input  logic                  rx_ack,
    input  logic [7:0]            rx_data,
    output logic [7:0]            tx_data,
    output logic [NUM_REGS*8-1:0] reg_out,
    output logic                  wr_stb,
    output logic [6:0]            wr_addr,
    output logic                  frame_done,
    output logic [7:0]            byte_cnt,
    output logic                  err,
    input  logic                  err_clr
);
    typedef enum logic [1:0] {IDLE, CMD, WR_DATA, RD_DATA} state_t;
    localparam logic [7:0] NR = 8'(NUM_REGS);
    state_t state, state_nx;
    logic [7:0] regs [NUM_REGS];
    logic [6:0] addr, addr_inc;
    logic [7:0] cnt, rd_cmd, rd_nx;
    logic cs_q, acc, oor_cmd, oor_nx, in_range;
    assign acc      = rx_ack & ~cs & (state != IDLE);
    assign addr_inc = addr + 7'd1;
    assign oor_cmd  = {1'b0, rx_data[6:0]} >= NR;
    assign oor_nx   = {1'b0, addr_inc} >= NR;
    assign in_range = {1'b0, addr} < NR;
    genvar i;
    for (i = 0; i < NUM_REGS; i++) begin : g_out
        assign reg_out[8*i +: 8] = regs[i];
    end
    // read muxes for the command address and the next sequential address
    always_comb begin
        rd_cmd = ERR_BYTE;
        rd_nx  = ERR_BYTE;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rx_data[6:0] == 7'(k)) rd_cmd = regs[k];
            if (addr_inc == 7'(k)) rd_nx = regs[k];
        end
    end
    // state register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // next state: cs high always aborts, command byte picks read or write
    always_comb begin
        state_nx = state;
        if (cs) state_nx = IDLE;
        else if (state == IDLE) state_nx = CMD;
        else if (state == CMD && rx_ack) state_nx = rx_data[7] ? RD_DATA : WR_DATA;
    end
    // datapath: registers, tx byte, strobes, frame counter and error flag
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= RST_VAL;
            tx_data    <= STATUS_BYTE;
            addr       <= 7'd0;
            cnt        <= 8'd0;
            cs_q       <= 1'b1;
            wr_stb     <= 1'b0;
            wr_addr    <= 7'd0;
            frame_done <= 1'b0;
            byte_cnt   <= 8'd0;
            err        <= 1'b0;
        end else begin
            cs_q       <= cs;
            wr_stb     <= 1'b0;
            frame_done <= cs & ~cs_q;
            if (cs & ~cs_q) byte_cnt <= cnt;
            if (err_clr) err <= 1'b0;
            if (cs) tx_data <= STATUS_BYTE;
            if (!cs && state == IDLE) cnt <= 8'd0;
            else if (acc && cnt != 8'hFF) cnt <= cnt + 8'd1;
            if (acc && state == CMD) begin
                addr    <= rx_data[6:0];
                tx_data <= rx_data[7] ? rd_cmd : STATUS_BYTE;
                if (rx_data[7] && oor_cmd) err <= 1'b1;
            end
            if (acc && state == WR_DATA) begin
                addr <= addr_inc;
                if (in_range) begin
                    for (int k = 0; k < NUM_REGS; k++) if (addr == 7'(k)) regs[k] <= rx_data;
                    wr_stb  <= 1'b1;
                    wr_addr <= addr;
                end else begin
                    err <= 1'b1;
                end
            end
            if (acc && state == RD_DATA) begin
                addr    <= addr_inc;
                tx_data <= rd_nx;
                if (oor_nx) err <= 1'b1;
            end
        end
    end
endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Sits directly downstream of the SPI slave byte engine and turns its byte stream into register accesses on a local register bank.
- Consumes the slave's per-byte receive data and acknowledge pulse, decodes a command byte, then writes or reads consecutive registers.
- Drives the slave's transmit byte, so that read data is shifted out on the byte that follows the command.
- The rest of the FPGA sees the register bank as flat parallel outputs plus a write strobe.

Parameters:
- NUM_REGS, 16, number of implemented 8-bit registers (1..128), at addresses 0..NUM_REGS-1.
- STATUS_BYTE, 8'hA5, byte returned during the command byte and for write-frame data bytes.
- ERR_BYTE, 8'hEE, byte returned when reading an address >= NUM_REGS.
- RST_VAL, 8'h00, reset value of every register.

Ports:
- sys_clk, input, 1, system clock; all logic is on the rising edge.
- sys_rst_n, input, 1, reset; synchronous, active-low.
- cs, input, 1, SPI chip select, already synchronous to sys_clk, active-low; high = no frame.
- rx_ack, input, 1, one-cycle pulse, one per completed SPI byte.
- rx_data, input, 8, received byte; valid when rx_ack=1.
- tx_data, output, 8, byte for the slave to shift out on the next SPI byte.
- reg_out, output, NUM_REGS*8, register bank; register n occupies bits [8n+7:8n].
- wr_stb, output, 1, one-cycle pulse when a register is written.
- wr_addr, output, 7, address of the write; valid with wr_stb.
- frame_done, output, 1, one-cycle pulse on the cycle after cs rises.
- byte_cnt, output, 8, bytes received in the last frame; saturates at 255; updated with frame_done.
- err, output, 1, sticky flag: a frame accessed an address >= NUM_REGS.
- err_clr, input, 1, synchronous clear of err.

Behaviour:
Reset (sys_rst_n=0 at a clock edge):
- state=IDLE; tx_data=STATUS_BYTE; every register=RST_VAL.
- wr_stb=0, wr_addr=0, frame_done=0, byte_cnt=0, err=0.
- Reset mid-frame abandons the frame and produces no write.

State machine (IDLE, CMD, WR_DATA, RD_DATA):
- IDLE -> CMD when cs=0. tx_data holds STATUS_BYTE.
- CMD: on rx_ack, latch addr=rx_data[6:0].
  - rx_data[7]=0: go to WR_DATA; tx_data=STATUS_BYTE.
  - rx_data[7]=1: go to RD_DATA; tx_data=rd(addr).
- WR_DATA: on each rx_ack:
  - addr < NUM_REGS: reg[addr]<=rx_data; wr_stb=1 and wr_addr=addr on the next cycle.
  - addr >= NUM_REGS: write dropped, no wr_stb, err<=1.
  - Then addr<=addr+1.
- RD_DATA: on each rx_ack, addr<=addr+1 and tx_data<=rd(addr+1). Received bytes are ignored.
- rd(a) = reg[a] if a < NUM_REGS; otherwise ERR_BYTE, and err<=1 when that byte is loaded.

Timing and boundary conditions:
- tx_data updates on the clock edge after rx_ack; latency is 1 cycle. The slave needs 2 or more sys_clk cycles between bytes, which is guaranteed.
- addr is 7-bit and wraps 127 -> 0.
- cs=1 in any state forces IDLE and tx_data=STATUS_BYTE on the next edge.
- rx_ack while cs=1 is ignored.
- rx_ack and cs=1 in the same cycle: cs wins and the byte is dropped.
- Frame counter: byte_cnt_int clears on entry to CMD and increments on each accepted rx_ack.
- cs 0->1 (edge detected with a registered cs copy): next cycle frame_done=1 and byte_cnt<=byte_cnt_int.
- A frame with only the command byte performs no access.
- A read frame never modifies registers.
- err_clr and an err set in the same cycle: set wins.
- Write data is visible on reg_out the cycle after rx_ack, in the same cycle as wr_stb.

Test Plan:
- Reset, then a frame with cmd 8'h03 and data 8'h5A -> reg3=8'h5A, wr_stb pulses once with wr_addr=3, byte_cnt=2, err=0.
- Burst write cmd 8'h0E with 8'h11, 8'h22, 8'h33 (NUM_REGS=16):
  - reg14=8'h11, reg15=8'h22.
  - Third byte targets address 16, so it is dropped and err=1.
  - Exactly 2 wr_stb pulses.
- Preload reg0..reg2=8'h10,8'h20,8'h30, then a read frame cmd 8'h80 with 3 dummy bytes:
  - tx_data during the cmd byte is 8'hA5.
  - tx_data then goes 8'h10, 8'h20, 8'h30, each updated 1 cycle after rx_ack.
  - No wr_stb.
- Read cmd 8'hFF with 2 dummy bytes -> tx_data=8'hEE, then addr wraps to 0 and tx_data=reg0; err=1; err_clr next cycle -> err=0.
- Raise cs in the same cycle as rx_ack of the second write byte -> no write, state IDLE, frame_done pulse, byte_cnt=1.
- Assert sys_rst_n=0 mid burst write -> all registers=RST_VAL, tx_data=8'hA5, no wr_stb. The next frame decodes normally.
